// File: rtl/hazard_stall_controller_if.sv
// hazard_stall_controller_if: ID-stage operand info, pipeline control and MEM-stage SRAM handshake
interface hazard_stall_controller_if;
  logic       id_valid;
  logic [3:0] id_src1;
  logic [3:0] id_src2;
  logic       id_two_src;
  logic [3:0] id_dest;
  logic       id_wb_en;
  logic       id_mem_r_en;
  logic       id_mem_w_en;
  logic       ex_br_taken;
  logic       mem_ack;
  logic       stall;
  logic       flush;
  logic       freeze;
  logic       mem_req;
  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en, id_mem_w_en,
    output ex_br_taken, mem_ack,
    input  stall, flush, freeze, mem_req
  );
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_dest, id_wb_en, id_mem_r_en, id_mem_w_en,
    input  ex_br_taken, mem_ack,
    output stall, flush, freeze, mem_req
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: ID-stage stall/flush/freeze decisions, EXE/MEM destination tracking and SRAM handshake
module hazard_stall_controller #(
  parameter bit FWD_RESET = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_stall_controller_if.slave  bus,
  input  logic                      fwd_en_cfg,
  output logic                      fwd_mode,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_op;
  } slot_t;
  typedef enum logic {RUN, MEM_WAIT} state_t;
  slot_t  ex_slot, mem_slot, id_info;
  state_t state, state_nx;
  logic   served, pending, hazard, ex_hit, mem_hit, admit;
  function automatic logic match(slot_t s, logic [3:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction
  // operand hazards against EXE and MEM producers; WB writes early enough to never matter
  always_comb begin
    ex_hit  = match(ex_slot, bus.id_src1) | (bus.id_two_src & match(ex_slot, bus.id_src2));
    mem_hit = match(mem_slot, bus.id_src1) | (bus.id_two_src & match(mem_slot, bus.id_src2));
    hazard  = bus.id_valid & (fwd_mode ? (ex_hit & ex_slot.mem_r_en) : (ex_hit | mem_hit));
    id_info = {bus.id_valid, bus.id_dest, bus.id_wb_en, bus.id_mem_r_en, bus.id_mem_r_en | bus.id_mem_w_en};
  end
  // handshake FSM: freeze while the MEM-stage access is outstanding, including its ack cycle
  always_comb begin
    pending     = mem_slot.valid & mem_slot.mem_op & ~served;
    bus.mem_req = (state == MEM_WAIT);
    bus.freeze  = (state == MEM_WAIT) | pending;
    state_nx    = (state == MEM_WAIT) ? (bus.mem_ack ? RUN : MEM_WAIT) : (pending ? MEM_WAIT : RUN);
    bus.flush   = bus.ex_br_taken & ~bus.freeze;
    bus.stall   = hazard & ~bus.freeze & ~bus.ex_br_taken;
    admit       = bus.id_valid & ~bus.stall & ~bus.flush;
  end
  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nx;
  end
  // tracker slots advance unless frozen; served marks a completed access until its slot moves on
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      served   <= 1'b0;
    end else if (!bus.freeze) begin
      mem_slot <= ex_slot;
      ex_slot  <= admit ? id_info : '0;
      served   <= 1'b0;
    end else if (state == MEM_WAIT && bus.mem_ack) begin
      served   <= 1'b1;
    end
  end
  // forwarding mode switches only on an edge with an empty, running pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               fwd_mode <= FWD_RESET;
    else if (!ex_slot.valid && !mem_slot.valid && !bus.freeze) fwd_mode <= fwd_en_cfg;
  end
  // saturating stall/flush cycle counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (bus.flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed vectors for hazard_stall_controller
module tb_hazard_stall_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fwd_en_cfg;
  logic       fwd_mode;
  logic [2:0] stall_cnt, flush_cnt;
  int         tests = 0;
  int         fails = 0;
  hazard_stall_controller_if bus();
  hazard_stall_controller #(.FWD_RESET(1'b1), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus), .fwd_en_cfg(fwd_en_cfg),
    .fwd_mode(fwd_mode), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic [3:0] d, input logic wb, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_src1 = s1; bus.id_src2 = s2; bus.id_two_src = two;
    bus.id_dest = d; bus.id_wb_en = wb; bus.id_mem_r_en = mr; bus.id_mem_w_en = mw;
  endtask
  task automatic idle;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    idle;
    bus.ex_br_taken = 0; bus.mem_ack = 0; fwd_en_cfg = 1;
    #12;
    chk("rst_stall", bus.stall, 0);
    chk("rst_flush", bus.flush, 0);
    chk("rst_freeze", bus.freeze, 0);
    chk("rst_req", bus.mem_req, 0);
    chk("rst_fwd", fwd_mode, 1);
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    rst = 1;
    tick;
    set_id(1, 1, 0, 0, 2, 1, 1, 0); #1;
    chk("lu_pre", bus.stall, 0);
    tick; set_id(1, 2, 0, 0, 4, 1, 0, 0); #1;
    chk("lu_stall", bus.stall, 1);
    tick;
    chk("lu_freeze", bus.freeze, 1);
    chk("lu_nostall", bus.stall, 0);
    chk("lu_cnt", stall_cnt, 1);
    tick; bus.mem_ack = 1; #1;
    chk("lu_req", bus.mem_req, 1);
    tick; bus.mem_ack = 0; #1;
    chk("lu_release", bus.freeze, 0);
    chk("lu_admit", bus.stall, 0);
    tick; idle; tick; tick;
    set_id(1, 1, 0, 0, 3, 1, 0, 0);
    tick; set_id(1, 3, 0, 0, 5, 1, 0, 0); #1;
    chk("fon_alu_ex", bus.stall, 0);
    tick;
    chk("fon_alu_mem", bus.stall, 0);
    idle; tick; tick; tick;
    set_id(1, 1, 0, 0, 5, 1, 0, 0);
    tick; idle; fwd_en_cfg = 0; #1;
    chk("fm_busy_ex", fwd_mode, 1);
    tick;
    chk("fm_busy_mem", fwd_mode, 1);
    tick;
    chk("fm_drain_hold", fwd_mode, 1);
    tick;
    chk("fm_switch", fwd_mode, 0);
    set_id(1, 1, 0, 0, 3, 1, 0, 0);
    tick; set_id(1, 7, 3, 1, 8, 1, 0, 0); #1;
    chk("foff_ex", bus.stall, 1);
    tick;
    chk("foff_mem", bus.stall, 1);
    tick;
    chk("foff_clear", bus.stall, 0);
    chk("foff_cnt", stall_cnt, 3);
    tick; idle; tick; tick;
    set_id(1, 1, 0, 0, 3, 1, 0, 0);
    tick; set_id(1, 1, 3, 0, 8, 1, 0, 0); #1;
    chk("foff_src2_off", bus.stall, 0);
    tick; idle; tick; tick;
    set_id(1, 1, 0, 0, 6, 1, 0, 0);
    tick; set_id(1, 6, 0, 0, 9, 1, 0, 0); bus.ex_br_taken = 1; #1;
    chk("br_flush", bus.flush, 1);
    chk("br_stall", bus.stall, 0);
    tick; bus.ex_br_taken = 0; set_id(1, 9, 0, 0, 10, 1, 0, 0); #1;
    chk("br_cnt", flush_cnt, 1);
    chk("br_bubble", bus.stall, 0);
    tick; idle; tick; tick;
    set_id(1, 1, 2, 1, 0, 0, 0, 1);
    tick; idle; #1;
    chk("st_ex", bus.freeze, 0);
    tick;
    chk("st_entry_frz", bus.freeze, 1);
    chk("st_entry_req", bus.mem_req, 0);
    for (int i = 1; i <= 4; i++) begin
      tick;
      if (i == 4) bus.mem_ack = 1;
      #1;
      chk("st_req", bus.mem_req, 1);
      chk("st_frz", bus.freeze, 1);
    end
    tick; bus.mem_ack = 0; #1;
    chk("st_release", bus.freeze, 0);
    chk("st_release_req", bus.mem_req, 0);
    tick;
    chk("st_no_rereq", bus.mem_req, 0);
    bus.mem_ack = 1;
    tick; bus.mem_ack = 0; #1;
    chk("ack_run_req", bus.mem_req, 0);
    chk("ack_run_frz", bus.freeze, 0);
    bus.ex_br_taken = 1;
    repeat (8) tick;
    bus.ex_br_taken = 0; #1;
    chk("flush_sat", flush_cnt, 7);
    chk("scnt_hold", stall_cnt, 3);
    set_id(1, 1, 2, 1, 0, 0, 0, 1);
    tick; idle; tick; tick;
    chk("rw_req", bus.mem_req, 1);
    fwd_en_cfg = 1; rst = 0; #1;
    chk("rw_req_drop", bus.mem_req, 0);
    chk("rw_frz_drop", bus.freeze, 0);
    chk("rw_scnt", stall_cnt, 0);
    chk("rw_fcnt", flush_cnt, 0);
    chk("rw_fwd", fwd_mode, 1);
    #2; rst = 1;
    tick;
    chk("post_frz", bus.freeze, 0);
    chk("post_req", bus.mem_req, 0);
    chk("post_fwd", fwd_mode, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
